rv_id_stage: RTL and testbench
==============================

Name: rv_id_stage

Overview:
Instruction-decode stage of the risc-v_ap pipeline. It drives the register-file read addresses and collects the read data. It resolves data hazards by bypassing from EX, MEM and WB, detects load-use hazards and stalls for them, and extracts the immediate. Its output is the registered ID/EX pipeline register that feeds the execute stage.

Parameters:
XLEN, 32, datapath width; the block supports only 32.
RESET_PC, 32'h0000_0000, value of pc_o after reset and after a bubble.

Ports:
clk_i  in  1  clock; one clock; reset is asynchronous and active-low
rstn_i  in  1  asynchronous active-low reset
valid_i  in  1  instr_i/pc_i hold a valid instruction from IF
instr_i  in  32  instruction word
pc_i  in  32  PC of instr_i
stall_o  out  1  combinational load-use stall; IF holds instr_i/pc_i while high
flush_i  in  1  kill the instruction being captured (taken branch/jump)
hold_i  in  1  EX back-pressure; freeze the ID/EX register
rs1_add_o  out  5  register-file read address, instr_i[19:15]
rs2_add_o  out  5  register-file read address, instr_i[24:20]
rs1_data_i  in  32  register-file read data
rs2_data_i  in  32  register-file read data
ex_we_i, ex_is_load_i  in  1 each  EX-stage instruction writes rd / is a load
ex_rd_add_i  in  5  EX destination; ex_data_i in 32, EX ALU result
mem_we_i  in  1  MEM stage writes rd; mem_rd_add_i in 5; mem_data_i in 32
wb_we_i  in  1  WB write enable (same signals as register-file write port); wb_rd_add_i in 5; wb_data_i in 32
valid_o  out  1  ID/EX register holds a valid instruction
pc_o, instr_o  out  32 each  registered PC / instruction
rs1_val_o, rs2_val_o  out  32 each  registered resolved operands
imm_o  out  32  registered sign-extended immediate
rd_add_o  out  5  registered destination; rd_we_o out 1, registered write enable (0 if rd==0)

Behaviour:
- Reset (rstn_i=0, async): valid_o=0, rd_we_o=0, pc_o=RESET_PC, all other registered outputs=0. Reset may be asserted mid-stall; the block comes out of reset with no pending stall state. It is purely combinational except for the ID/EX register.
- rs1_add_o/rs2_add_o are combinational from instr_i and are driven whenever valid_i=0 too.
- Source usage, by opcode = instr_i[6:0]:
  - uses_rs1 is 0 for LUI (0110111), AUIPC (0010111), JAL (1101111), else 1.
  - uses_rs2 is 1 only for OP (0110011), STORE (0100011), BRANCH (1100011).
- Operand resolution per source, first match wins:
  - address==0 -> 0;
  - ex_we_i & !ex_is_load_i & ex_rd==addr -> ex_data_i;
  - mem_we_i & mem_rd==addr -> mem_data_i;
  - wb_we_i & wb_rd==addr -> wb_data_i (the register file write is not yet visible);
  - otherwise the register-file data.
- stall_o = valid_i & !flush_i & ex_we_i & ex_is_load_i & ex_rd_add_i!=0 & ((uses_rs1 & ex_rd==rs1) | (uses_rs2 & ex_rd==rs2)). stall_o is combinational and has zero latency.
- Immediate: I-type (LOAD, OP-IMM, JALR) {20{i[31]},i[31:20]}; S-type; B-type (bit0=0); U-type {i[31:12],12'b0}; J-type (bit0=0). OP and all others produce 0.
- rd_we_o=1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR with rd!=0; otherwise 0.
- ID/EX register update on each posedge, priority high to low:
  1. hold_i=1 -> all outputs unchanged. This overrides flush_i and stall_o; EX is responsible for holding the upstream stages too.
  2. flush_i=1 -> bubble: valid_o=0, rd_we_o=0, other fields don't-care (implementation loads RESET_PC/0).
  3. stall_o=1 -> bubble inserted; the instruction stays in IF/ID and is re-evaluated next cycle, when the load is in MEM and is forwarded from mem_data_i.
  4. valid_i=0 -> bubble.
  5. otherwise capture instr_i, pc_i, resolved operands, imm, rd, rd_we, and set valid_o=1.
- Latency: 1 cycle from IF/ID to ID/EX. A load-use hazard costs exactly 1 bubble.

Test Plan:
- Reset mid-stream: a valid instruction is present and rstn_i is pulsed low between clock edges -> valid_o=0, rd_we_o=0 immediately, pc_o=0; after release the first instruction is captured normally.
- Immediate decode: ADDI x1,x0,-1 (0xFFF00093) -> imm_o=0xFFFFFFFF, rd_add_o=1, rd_we_o=1, rs1_val_o=0. BEQ with offset -4 (0xFE000EE3) -> imm_o=0xFFFFFFFC, rd_we_o=0.
- Bypass priority: ADD x3,x1,x2 with ex(x1,0x11), mem(x1,0x22), wb(x2,0x33) and register file returning 0xAA -> rs1_val_o=0x11, rs2_val_o=0x33. With ex_we_i dropped -> rs1_val_o=0x22.
- x0 rule: all bypass sources target x0 with 0xDEAD and rs1=rs2=0 -> rs1_val_o=0, rs2_val_o=0; ADDI x0,x0,5 -> rd_we_o=0.
- Load-use: ex is a load to x5 and ID holds ADD x6,x5,x0 -> stall_o=1 for one cycle and a bubble is captured. Next cycle the load is in MEM with mem_data_i=0x1234 -> rs1_val_o=0x1234, valid_o=1. LUI x6 after a load to x5 -> no stall.
- Flush/hold: flush_i together with stall_o -> stall_o=0 and a bubble is captured. hold_i=1 for 3 cycles while inputs change -> all outputs unchanged; hold_i together with flush_i -> outputs unchanged.

Source files
------------

// File: rtl/rv_id_stage.sv
// rtl/rv_id_stage.sv - RISC-V instruction decode stage with operand bypass, load-use stall and ID/EX register
module rv_id_stage #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            valid_i,
    input  logic [31:0]     instr_i,
    input  logic [31:0]     pc_i,
    output logic            stall_o,
    input  logic            flush_i,
    input  logic            hold_i,
    output logic [4:0]      rs1_add_o,
    output logic [4:0]      rs2_add_o,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            ex_we_i,
    input  logic            ex_is_load_i,
    input  logic [4:0]      ex_rd_add_i,
    input  logic [XLEN-1:0] ex_data_i,
    input  logic            mem_we_i,
    input  logic [4:0]      mem_rd_add_i,
    input  logic [XLEN-1:0] mem_data_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_rd_add_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            valid_o,
    output logic [31:0]     pc_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] rs1_val_o,
    output logic [XLEN-1:0] rs2_val_o,
    output logic [31:0]     imm_o,
    output logic [4:0]      rd_add_o,
    output logic            rd_we_o
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rs1_add;
    logic [4:0]      w_rs2_add;
    logic [4:0]      w_rd_add;
    logic            w_uses_rs1;
    logic            w_uses_rs2;
    logic            w_rd_we;
    logic            w_stall;
    logic [31:0]     w_imm;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;

    logic            r_valid;
    logic [31:0]     r_pc;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_rs1_val;
    logic [XLEN-1:0] r_rs2_val;
    logic [31:0]     r_imm;
    logic [4:0]      r_rd_add;
    logic            r_rd_we;

    // A load in EX has no data yet, so it is never a bypass source; the stall covers that case.
    function automatic logic [XLEN-1:0] f_resolve(input logic [4:0] add, input logic [XLEN-1:0] rf_data);
        if (add == 5'd0)
            return '0;
        else if (ex_we_i && !ex_is_load_i && ex_rd_add_i == add)
            return ex_data_i;
        else if (mem_we_i && mem_rd_add_i == add)
            return mem_data_i;
        else if (wb_we_i && wb_rd_add_i == add)
            return wb_data_i;
        else
            return rf_data;
    endfunction

    always_comb begin
        w_opcode  = instr_i[6:0];
        w_rs1_add = instr_i[19:15];
        w_rs2_add = instr_i[24:20];
        w_rd_add  = instr_i[11:7];

        w_uses_rs1 = !(w_opcode == OPC_LUI || w_opcode == OPC_AUIPC || w_opcode == OPC_JAL);
        w_uses_rs2 = (w_opcode == OPC_OP || w_opcode == OPC_STORE || w_opcode == OPC_BRANCH);

        w_rd_we = 1'b0;
        w_imm   = 32'd0;
        case (w_opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                w_imm   = {{20{instr_i[31]}}, instr_i[31:20]};
                w_rd_we = (w_rd_add != 5'd0);
            end
            OPC_STORE:  w_imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            OPC_BRANCH: w_imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC: begin
                w_imm   = {instr_i[31:12], 12'd0};
                w_rd_we = (w_rd_add != 5'd0);
            end
            OPC_JAL: begin
                w_imm   = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
                w_rd_we = (w_rd_add != 5'd0);
            end
            OPC_OP:  w_rd_we = (w_rd_add != 5'd0);
            default: w_imm = 32'd0;
        endcase

        w_rs1_val = f_resolve(w_rs1_add, rs1_data_i);
        w_rs2_val = f_resolve(w_rs2_add, rs2_data_i);

        w_stall = valid_i && !flush_i && ex_we_i && ex_is_load_i && (ex_rd_add_i != 5'd0) &&
                  ((w_uses_rs1 && ex_rd_add_i == w_rs1_add) || (w_uses_rs2 && ex_rd_add_i == w_rs2_add));
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_valid   <= 1'b0;
            r_pc      <= RESET_PC;
            r_instr   <= 32'd0;
            r_rs1_val <= '0;
            r_rs2_val <= '0;
            r_imm     <= 32'd0;
            r_rd_add  <= 5'd0;
            r_rd_we   <= 1'b0;
        end else if (!hold_i) begin
            if (flush_i || w_stall || !valid_i) begin
                r_valid   <= 1'b0;
                r_pc      <= RESET_PC;
                r_instr   <= 32'd0;
                r_rs1_val <= '0;
                r_rs2_val <= '0;
                r_imm     <= 32'd0;
                r_rd_add  <= 5'd0;
                r_rd_we   <= 1'b0;
            end else begin
                r_valid   <= 1'b1;
                r_pc      <= pc_i;
                r_instr   <= instr_i;
                r_rs1_val <= w_rs1_val;
                r_rs2_val <= w_rs2_val;
                r_imm     <= w_imm;
                r_rd_add  <= w_rd_add;
                r_rd_we   <= w_rd_we;
            end
        end
    end

    assign stall_o   = w_stall;
    assign rs1_add_o = w_rs1_add;
    assign rs2_add_o = w_rs2_add;
    assign valid_o   = r_valid;
    assign pc_o      = r_pc;
    assign instr_o   = r_instr;
    assign rs1_val_o = r_rs1_val;
    assign rs2_val_o = r_rs2_val;
    assign imm_o     = r_imm;
    assign rd_add_o  = r_rd_add;
    assign rd_we_o   = r_rd_we;

endmodule

// File: tb/tb_rv_id_stage.sv
// tb/tb_rv_id_stage.sv - table-driven self-checking bench for rv_id_stage
module tb_rv_id_stage;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b1;
    logic        valid_i = 1'b0;
    logic [31:0] instr_i = '0;
    logic [31:0] pc_i = '0;
    logic        stall_o;
    logic        flush_i = 1'b0;
    logic        hold_i = 1'b0;
    logic [4:0]  rs1_add_o, rs2_add_o;
    logic [31:0] rs1_data_i = '0, rs2_data_i = '0;
    logic        ex_we_i = 1'b0, ex_is_load_i = 1'b0;
    logic [4:0]  ex_rd_add_i = '0;
    logic [31:0] ex_data_i = '0;
    logic        mem_we_i = 1'b0;
    logic [4:0]  mem_rd_add_i = '0;
    logic [31:0] mem_data_i = '0;
    logic        wb_we_i = 1'b0;
    logic [4:0]  wb_rd_add_i = '0;
    logic [31:0] wb_data_i = '0;
    logic        valid_o;
    logic [31:0] pc_o, instr_o, rs1_val_o, rs2_val_o, imm_o;
    logic [4:0]  rd_add_o;
    logic        rd_we_o;

    int checks = 0;
    int failures = 0;

    rv_id_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .valid_i(valid_i), .instr_i(instr_i), .pc_i(pc_i),
        .stall_o(stall_o), .flush_i(flush_i), .hold_i(hold_i),
        .rs1_add_o(rs1_add_o), .rs2_add_o(rs2_add_o), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .ex_we_i(ex_we_i), .ex_is_load_i(ex_is_load_i), .ex_rd_add_i(ex_rd_add_i), .ex_data_i(ex_data_i),
        .mem_we_i(mem_we_i), .mem_rd_add_i(mem_rd_add_i), .mem_data_i(mem_data_i),
        .wb_we_i(wb_we_i), .wb_rd_add_i(wb_rd_add_i), .wb_data_i(wb_data_i),
        .valid_o(valid_o), .pc_o(pc_o), .instr_o(instr_o), .rs1_val_o(rs1_val_o), .rs2_val_o(rs2_val_o),
        .imm_o(imm_o), .rd_add_o(rd_add_o), .rd_we_o(rd_we_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1d, rs2d;
        logic        ex_we, ex_ld;
        logic [4:0]  ex_rd;
        logic [31:0] ex_d;
        logic        mem_we;
        logic [4:0]  mem_rd;
        logic [31:0] mem_d;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_d;
        logic        e_stall;
        logic [31:0] e_rs1, e_rs2, e_imm;
        logic [4:0]  e_rd;
        logic        e_we;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input logic [31:0] pc);
        valid_i = 1'b1; flush_i = 1'b0; hold_i = 1'b0;
        instr_i = v.instr; pc_i = pc;
        rs1_data_i = v.rs1d; rs2_data_i = v.rs2d;
        ex_we_i = v.ex_we; ex_is_load_i = v.ex_ld; ex_rd_add_i = v.ex_rd; ex_data_i = v.ex_d;
        mem_we_i = v.mem_we; mem_rd_add_i = v.mem_rd; mem_data_i = v.mem_d;
        wb_we_i = v.wb_we; wb_rd_add_i = v.wb_rd; wb_data_i = v.wb_d;
    endtask

    initial begin
        logic [31:0] w;
        //                instr         rs1d   rs2d  exwe ld rd  exd      mwe rd mdata   wwe rd wdata   stall rs1    rs2    imm            rd we
        vecs[0]  = '{32'hFFF00093, 'hAA, 'hBB, 0, 0, 0,  0,       0, 0, 0,       0, 0, 0,       0, 'h0,  'hBB, 32'hFFFFFFFF, 1,  1};
        vecs[1]  = '{32'hFE000EE3, 'hAA, 'hBB, 0, 0, 0,  0,       0, 0, 0,       0, 0, 0,       0, 'h0,  'h0,  32'hFFFFFFFC, 29, 0};
        vecs[2]  = '{32'h002081B3, 'hAA, 'hAA, 1, 0, 1,  'h11,    1, 1, 'h22,    1, 2, 'h33,    0, 'h11, 'h33, 32'h0,        3,  1};
        vecs[3]  = '{32'h002081B3, 'hAA, 'hAA, 0, 0, 1,  'h11,    1, 1, 'h22,    1, 2, 'h33,    0, 'h22, 'h33, 32'h0,        3,  1};
        vecs[4]  = '{32'hFFF00093, 'hAA, 'hBB, 1, 1, 31, 'h99,    0, 0, 0,       0, 0, 0,       0, 'h0,  'hBB, 32'hFFFFFFFF, 1,  1};
        vecs[5]  = '{32'h00000033, 'hAA, 'hBB, 1, 0, 0,  'hDEAD,  1, 0, 'hDEAD,  1, 0, 'hDEAD,  0, 'h0,  'h0,  32'h0,        0,  0};
        vecs[6]  = '{32'h00500013, 'hAA, 'hBB, 0, 0, 0,  0,       0, 0, 0,       0, 0, 0,       0, 'h0,  'hBB, 32'h5,        0,  0};
        vecs[7]  = '{32'h12345337, 'hAA, 'hBB, 1, 1, 8,  'h77,    0, 0, 0,       0, 0, 0,       0, 'hAA, 'hBB, 32'h12345000, 6,  1};
        vecs[8]  = '{32'h008000EF, 'hAA, 'hBB, 0, 0, 0,  0,       0, 0, 0,       0, 0, 0,       0, 'h0,  'hBB, 32'h8,        1,  1};
        vecs[9]  = '{32'hFE20AC23, 'hAA, 'hBB, 0, 0, 0,  0,       0, 0, 0,       1, 1, 'h55,    0, 'h55, 'hBB, 32'hFFFFFFF8, 24, 0};
        vecs[10] = '{32'hFE20AC23, 'hAA, 'hBB, 1, 1, 2,  'h66,    0, 0, 0,       0, 0, 0,       1, 'h0,  'h0,  32'h0,        0,  0};
        vecs[11] = '{32'h00001297, 'hAA, 'hBB, 0, 0, 0,  0,       0, 0, 0,       0, 0, 0,       0, 'h0,  'h0,  32'h1000,     5,  1};
        vecs[12] = '{32'h002081B3, 'hAA, 'hBB, 0, 0, 0,  0,       1, 2, 'h44,    1, 2, 'h33,    0, 'hAA, 'h44, 32'h0,        3,  1};

        #1 rstn_i = 1'b0;
        #1;
        chk("reset valid_o", {31'd0, valid_o}, 32'd0);
        chk("reset rd_we_o", {31'd0, rd_we_o}, 32'd0);
        chk("reset pc_o", pc_o, 32'h0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        for (int i = 0; i < 13; i++) begin
            apply(vecs[i], 32'h100 + 32'(i) * 4);
            #1;
            w = vecs[i].instr;
            chk($sformatf("v%0d stall_o", i), {31'd0, stall_o}, {31'd0, vecs[i].e_stall});
            chk($sformatf("v%0d rs1_add_o", i), {27'd0, rs1_add_o}, {27'd0, w[19:15]});
            chk($sformatf("v%0d rs2_add_o", i), {27'd0, rs2_add_o}, {27'd0, w[24:20]});
            @(posedge clk_i); #1;
            chk($sformatf("v%0d valid_o", i), {31'd0, valid_o}, {31'd0, ~vecs[i].e_stall});
            chk($sformatf("v%0d rd_we_o", i), {31'd0, rd_we_o}, {31'd0, vecs[i].e_we});
            if (!vecs[i].e_stall) begin
                chk($sformatf("v%0d pc_o", i), pc_o, 32'h100 + 32'(i) * 4);
                chk($sformatf("v%0d instr_o", i), instr_o, vecs[i].instr);
                chk($sformatf("v%0d rs1_val_o", i), rs1_val_o, vecs[i].e_rs1);
                chk($sformatf("v%0d rs2_val_o", i), rs2_val_o, vecs[i].e_rs2);
                chk($sformatf("v%0d imm_o", i), imm_o, vecs[i].e_imm);
                chk($sformatf("v%0d rd_add_o", i), {27'd0, rd_add_o}, {27'd0, vecs[i].e_rd});
            end
            @(negedge clk_i);
        end

        // Load-use: ADD x6,x5,x0 behind a load to x5, then the load moves to MEM
        apply(vecs[0], 32'h400);
        instr_i = 32'h00028333; rs1_data_i = 32'hAA; rs2_data_i = 32'hBB;
        ex_we_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_add_i = 5'd5; ex_data_i = 32'hBAD;
        #1 chk("lu stall_o", {31'd0, stall_o}, 32'd1);
        @(posedge clk_i); #1;
        chk("lu bubble valid_o", {31'd0, valid_o}, 32'd0);
        @(negedge clk_i);
        ex_we_i = 1'b0; ex_is_load_i = 1'b0;
        mem_we_i = 1'b1; mem_rd_add_i = 5'd5; mem_data_i = 32'h1234;
        #1 chk("lu stall_o released", {31'd0, stall_o}, 32'd0);
        @(posedge clk_i); #1;
        chk("lu valid_o", {31'd0, valid_o}, 32'd1);
        chk("lu rs1_val_o", rs1_val_o, 32'h1234);
        chk("lu rs2_val_o", rs2_val_o, 32'h0);
        chk("lu rd_add_o", {27'd0, rd_add_o}, 32'd6);

        // Flush together with a load-use hazard
        @(negedge clk_i);
        mem_we_i = 1'b0;
        ex_we_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_add_i = 5'd5;
        flush_i = 1'b1;
        #1 chk("flush stall_o", {31'd0, stall_o}, 32'd0);
        @(posedge clk_i); #1;
        chk("flush valid_o", {31'd0, valid_o}, 32'd0);
        chk("flush rd_we_o", {31'd0, rd_we_o}, 32'd0);

        // valid_i=0 gives a bubble after a valid capture
        @(negedge clk_i);
        apply(vecs[0], 32'h500);
        @(posedge clk_i); #1;
        chk("pre-idle valid_o", {31'd0, valid_o}, 32'd1);
        @(negedge clk_i);
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        chk("idle valid_o", {31'd0, valid_o}, 32'd0);

        // Hold freezes a captured ADDI while inputs change, also against flush
        @(negedge clk_i);
        apply(vecs[0], 32'h200);
        @(posedge clk_i); #1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            hold_i = 1'b1;
            flush_i = (c == 3);
            instr_i = 32'h002081B3 + 32'(c); pc_i = 32'h300 + 32'(c) * 4;
            ex_we_i = 1'b1; ex_is_load_i = 1'b0; ex_rd_add_i = 5'd1; ex_data_i = 32'h5A5A;
            @(posedge clk_i); #1;
            chk($sformatf("hold%0d valid_o", c), {31'd0, valid_o}, 32'd1);
            chk($sformatf("hold%0d pc_o", c), pc_o, 32'h200);
            chk($sformatf("hold%0d instr_o", c), instr_o, 32'hFFF00093);
            chk($sformatf("hold%0d imm_o", c), imm_o, 32'hFFFFFFFF);
            chk($sformatf("hold%0d rs2_val_o", c), rs2_val_o, 32'hBB);
            chk($sformatf("hold%0d rd_we_o", c), {31'd0, rd_we_o}, 32'd1);
        end
        @(negedge clk_i);
        hold_i = 1'b0;
        @(posedge clk_i); #1;
        chk("unhold flush valid_o", {31'd0, valid_o}, 32'd0);
        chk("unhold flush pc_o", pc_o, 32'h0);

        // Reset pulsed between edges while a stall condition is present
        @(negedge clk_i);
        apply(vecs[8], 32'h600);
        @(posedge clk_i); #1;
        chk("pre-reset valid_o", {31'd0, valid_o}, 32'd1);
        @(negedge clk_i);
        instr_i = 32'h00028333;
        ex_we_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_add_i = 5'd5;
        #2 rstn_i = 1'b0;
        #1;
        chk("mid reset valid_o", {31'd0, valid_o}, 32'd0);
        chk("mid reset rd_we_o", {31'd0, rd_we_o}, 32'd0);
        chk("mid reset pc_o", pc_o, 32'h0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        apply(vecs[2], 32'h700);
        #1 chk("post reset stall_o", {31'd0, stall_o}, 32'd0);
        @(posedge clk_i); #1;
        chk("post reset valid_o", {31'd0, valid_o}, 32'd1);
        chk("post reset pc_o", pc_o, 32'h700);
        chk("post reset rs1_val_o", rs1_val_o, 32'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
